// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with byte-enabled writes, asynchronous
// clear of every entry and a per-register busy scoreboard for long-latency writebacks.
//
// Optional feature: define RF_WB_BYPASS_EN to forward the writeback port onto the
// read ports in the same cycle. Without it, reads reflect only stored state.

module regfile_sb #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [DW-1:0]   wd,
  input  logic [DW/8-1:0] wbe,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [DW-1:0]   rd1,
  output logic [DW-1:0]   rd2,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_a,
  input  logic            sb_flush,
  output logic            busy1,
  output logic            busy2,
  output logic            any_busy
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned NB    = DW / 8;

  logic [DW-1:0]    rf_q [Depth];
  logic [DW-1:0]    rf_d [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic [Depth-1:0] wr_hit, set_hit;
  logic [DW-1:0]    wmask;

  logic [AW-1:0]    ra     [2];
  logic [DW-1:0]    rd_v   [2];
  logic             busy_v [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  // Expand byte enables into a bit mask over the data word.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < int'(NB); b++) begin
      wmask[8*b +: 8] = {8{wbe[b]}};
    end
  end

  // Decode write and scoreboard-set addresses; entry 0 is excluded when hardwired to zero.
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int e = 0; e < int'(Depth); e++) begin
      wr_hit[e]  = we && (wa == AW'(e)) && !(ZERO_R0 && (e == 0));
      set_hit[e] = sb_set && (sb_a == AW'(e)) && !(ZERO_R0 && (e == 0));
    end
  end

  // Next-state data: merge enabled bytes into the addressed entry.
  always_comb begin
    for (int e = 0; e < int'(Depth); e++) begin
      rf_d[e] = rf_q[e];
      if (wr_hit[e]) begin
        rf_d[e] = (wd & wmask) | (rf_q[e] & ~wmask);
      end
    end
  end

  // Next-state busy bits: flush beats set, and a new producer beats the writeback clear.
  always_comb begin
    busy_d = (busy_q & ~wr_hit) | set_hit;
    if (sb_flush) begin
      busy_d = '0;
    end
  end

  // Storage and scoreboard state; reset clears everything and aborts any write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < int'(Depth); e++) begin
        rf_q[e] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int e = 0; e < int'(Depth); e++) begin
        rf_q[e] <= rf_d[e];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports, with optional same-cycle writeback forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_v[p]   = '0;
      busy_v[p] = 1'b0;
      if (!(ZERO_R0 && (ra[p] == '0))) begin
        rd_v[p]   = rf_q[ra[p]];
        busy_v[p] = busy_q[ra[p]];
`ifdef RF_WB_BYPASS_EN
        if (we && (wa == ra[p])) begin
          rd_v[p]   = (wd & wmask) | (rf_q[ra[p]] & ~wmask);
          busy_v[p] = sb_set && (sb_a == ra[p]);
        end
`endif
      end
      // Forwarded write data must not leak out while reset is held.
      if (!rst) begin
        rd_v[p]   = '0;
        busy_v[p] = 1'b0;
      end
    end
  end

  // Drive the status and data outputs.
  always_comb begin
    rd1      = rd_v[0];
    rd2      = rd_v[1];
    busy1    = busy_v[0];
    busy2    = busy_v[1];
    any_busy = rst && (|busy_q);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters): directed vectors, a behavioural
// model checked every falling edge, and literal expectations from hand-worked cases.

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [3:0]  wbe = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1, rd2;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_a = '0;
  logic        sb_flush = 1'b0;
  logic        busy1, busy2, any_busy;

  int n_cmp = 0;
  int n_err = 0;

  bit bypass_on;

  logic [31:0] m_rf   [32];
  logic        m_busy [32];

  regfile_sb #(.DW(32), .AW(5), .ZERO_R0(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .wbe      (wbe),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .sb_set   (sb_set),
    .sb_a     (sb_a),
    .sb_flush (sb_flush),
    .busy1    (busy1),
    .busy2    (busy2),
    .any_busy (any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  // Model: what a read of address a must return right now.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst || a == 0) return 32'h0;
    if (bypass_on && we && wa == a) return merge(m_rf[a], wd, wbe);
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst || a == 0) return 1'b0;
    if (bypass_on && we && wa == a) return sb_set && (sb_a == a);
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) r = r | m_busy[i];
    return r && rst;
  endfunction

  // Model state update: a written register is free unless a new producer claims it this
  // cycle, and a flush wipes every claim.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i]   <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (we && wa != 0) m_rf[wa] <= merge(m_rf[wa], wd, wbe);
      if (sb_flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      end else begin
        if (we && wa != 0) m_busy[wa] <= 1'b0;
        if (sb_set && sb_a != 0) m_busy[sb_a] <= 1'b1;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", {31'b0, busy1}, {31'b0, exp_busy(ra1)});
    chk("busy2", {31'b0, busy2}, {31'b0, exp_busy(ra2)});
    chk("any_busy", {31'b0, any_busy}, {31'b0, exp_any()});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; wbe = '0;
    sb_set = 1'b0; sb_a = '0; sb_flush = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    idle();
    we = 1'b1; wa = a; wd = d; wbe = be;
    step();
    idle();
  endtask

  initial begin
`ifdef RF_WB_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end

    // Reset holds everything at zero, even with a write requested.
    we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF; wbe = 4'hF; ra1 = 5'd3;
    step(); step();
    #1;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_any", {31'b0, any_busy}, 32'h0);
    idle();
    rst = 1'b1;

    // Walk pattern through every register.
    for (int k = 1; k < 32; k++) wr(5'(k), 32'(32'h1111_1111 * k), 4'hF);
    wr(5'd0, 32'hDEAD_BEEF, 4'hF);
    for (int k = 1; k < 32; k++) begin
      ra1 = 5'(k); ra2 = 5'(32 - k);
      #1;
      chk("walk_rd1", rd1, 32'(32'h1111_1111 * k));
      chk("walk_rd2", rd2, 32'(32'h1111_1111 * (32 - k)));
    end
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("r0_zero", rd1, 32'h0);

    // Byte enables.
    wr(5'd5, 32'hAABB_CCDD, 4'hF);
    wr(5'd5, 32'h1122_3344, 4'b0101);
    ra1 = 5'd5;
    #1;
    chk("byte_en", rd1, 32'hAA22_CC44);

    // Scoreboard collision: a new producer supersedes a same-cycle writeback.
    sb_set = 1'b1; sb_a = 5'd7; ra1 = 5'd7;
    step(); idle();
    #1;
    chk("sb_set_busy", {31'b0, busy1}, 32'h1);
    chk("sb_set_any", {31'b0, any_busy}, 32'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0777; wbe = 4'hF; sb_set = 1'b1; sb_a = 5'd7;
    step(); idle();
    #1;
    chk("collide_busy", {31'b0, busy1}, 32'h1);
    wr(5'd7, 32'h0000_7777, 4'hF);
    #1;
    chk("wb_clear_busy", {31'b0, busy1}, 32'h0);
    chk("wb_clear_any", {31'b0, any_busy}, 32'h0);
    chk("wb_clear_data", rd1, 32'h0000_7777);

    // Zero register never becomes busy.
    sb_set = 1'b1; sb_a = 5'd0; ra1 = 5'd0;
    step(); idle();
    #1;
    chk("r0_not_busy", {31'b0, any_busy}, 32'h0);

    // Flush beats a same-cycle set.
    sb_set = 1'b1; sb_a = 5'd3; step();
    sb_a = 5'd9; step(); idle();
    ra1 = 5'd3; ra2 = 5'd9;
    #1;
    chk("pre_flush_b1", {31'b0, busy1}, 32'h1);
    chk("pre_flush_b2", {31'b0, busy2}, 32'h1);
    sb_flush = 1'b1; sb_set = 1'b1; sb_a = 5'd4;
    step(); idle();
    ra1 = 5'd4;
    #1;
    chk("flush_b4", {31'b0, busy1}, 32'h0);
    chk("flush_b9", {31'b0, busy2}, 32'h0);
    chk("flush_any", {31'b0, any_busy}, 32'h0);

    // Asynchronous reset mid-write.
    wr(5'd2, 32'h0000_0055, 4'hF);
    sb_set = 1'b1; sb_a = 5'd8; step(); idle();
    ra1 = 5'd2; ra2 = 5'd8;
    #1;
    chk("pre_rst_rd1", rd1, 32'h0000_0055);
    chk("pre_rst_any", {31'b0, any_busy}, 32'h1);
    we = 1'b1; wa = 5'd2; wd = 32'h0000_0099; wbe = 4'hF;
    #2 rst = 1'b0;
    #1;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_busy2", {31'b0, busy2}, 32'h0);
    chk("rst_any", {31'b0, any_busy}, 32'h0);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("post_rst_rd1", rd1, 32'h0);

    // Same-cycle writeback visibility.
    wr(5'd6, 32'h0, 4'hF);
    we = 1'b1; wa = 5'd6; wd = 32'h1234_5678; wbe = 4'hF; ra1 = 5'd6;
    #1;
    chk("bypass_rd1", rd1, bypass_on ? 32'h1234_5678 : 32'h0);
    step(); idle();
    #1;
    chk("after_edge_rd1", rd1, 32'h1234_5678);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's 2-read/1-write register file. It adds the following:
- configurable data width and depth;
- byte-enabled writes;
- full asynchronous clear of every entry;
- a per-register scoreboard (busy bits) that the pipeline uses to stall on pending multi-cycle writebacks (loads, mul/div).

It sits in the decode stage. Reads feed operand selection; the write port is driven from writeback.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 5, address width; depth = 2**AW entries.
- ZERO_R0, 1, 1 = entry 0 reads as 0, ignores writes and never becomes busy; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  DW  write data.
- wbe  in  DW/8  byte enables for the write; bit i covers wd[8i+7:8i].
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  DW  read data, port 1.
- rd2  out  DW  read data, port 2.
- sb_set  in  1  mark register sb_a busy (a long-latency producer has issued).
- sb_a  in  AW  scoreboard set address.
- sb_flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy1  out  1  busy bit of register ra1.
- busy2  out  1  busy bit of register ra2.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - all 2**AW entries clear to 0; all busy bits clear to 0.
  - rd1/rd2 = 0, busy1/busy2/any_busy = 0 for as long as rst=0.
  - Reset asserted mid-write aborts that write.
  - First write is accepted on the first rising edge with rst=1.
- Write:
  - On posedge with we=1, for each i with wbe[i]=1, rf[wa] byte i <= wd byte i; other bytes hold.
  - we=1 with wbe=0 changes no data but still clears the busy bit.
- Zero register:
  - With ZERO_R0=1, writes to wa=0 are discarded; sb_set to address 0 is ignored.
  - Reads of address 0 return 0 and busy=0.
- Read: combinational, zero added latency.
  - rdN = rf[raN] as stored before the current edge, unless the bypass feature applies.
- Scoreboard, evaluated at each posedge with per-entry priority sb_flush > sb_set > writeback clear:
  - sb_flush=1: all busy bits <= 0. A same-cycle sb_set is dropped; a same-cycle data write still happens.
  - sb_set=1 and sb_a=k: busy[k] <= 1. If we=1 and wa=k in the same cycle, the data is written and busy[k] still ends at 1, because the new producer supersedes.
  - we=1 and wa=k with no set to k: busy[k] <= 0.
  - sb_set to an already-busy entry keeps it at 1 (no count; single outstanding producer per register).
- Status outputs:
  - busyN is combinational from the registered busy bits of raN.
  - any_busy is registered-bit OR, combinational output.
- Out-of-range conditions: none. The address space is fully decoded.

Optional Feature:
Macro RF_WB_BYPASS_EN.
- Defined:
  - If we=1, wa=raN and the address is not the zero register, rdN combinationally returns the merged value: bytes with wbe=1 from wd, the rest from rf[raN].
  - busyN reads 0 in that cycle unless sb_set targets the same address.
  - Writeback and read can then occur in the same cycle without a stall.
- Not defined:
  - rdN and busyN reflect only stored state; new data is visible from the cycle after the write edge.

Test Plan:
1. Reset then walk: release rst, then write 0x11111111*k to regs 1..31 → all read back correctly on both ports; reg 0 reads 0 after a write of 0xDEADBEEF.
2. Byte enable: reg 5=0xAABBCCDD, then write wd=0x11223344 with wbe=4'b0101 → reg 5 = 0xAA22CC44.
3. Scoreboard collision: sb_set reg 7 → busy=1. Same cycle sb_set 7 plus we wa=7 → busy stays 1. Next we wa=7 → busy=0 and any_busy=0.
4. Flush priority: regs 3 and 9 busy, then sb_flush together with sb_set 4 → all busy=0, reg 4 not busy.
5. Async reset mid-op: drive rst=0 between edges while we=1 → rd1/rd2 and busy fall to 0 immediately; no write lands at the next edge.
6. Bypass (macro on): reg 6=0x0, same cycle we wa=6 wd=0x12345678 wbe=4'b1111 and ra1=6 → rd1=0x12345678 before the edge. Macro off → rd1=0x0 that cycle and 0x12345678 after the edge.
